// File: rtl/button_edge_detect.sv
// ---------------------------------------------------------------------------
// button_edge_detect
//
// Input conditioner for one active-low push button. The raw pin is passed
// through a synchronizer chain, debounced with a consecutive-sample counter,
// and each debounced press (1 -> 0 transition) produces a one-cycle pulse.
//
// Parameters
//   SYNC_STAGES      synchronizer depth, >= 2
//   DEBOUNCE_CYCLES  consecutive disagreeing samples needed to change level, >= 1
//
// Ports
//   clock                   system clock, rising edge
//   reset                   synchronous, active-high
//   button_value            raw asynchronous button level (0 = pressed)
//   negative_edge_detected  registered one-cycle pulse per debounced press
//   debounced_value         current debounced button level
//
// Debounce FSM
//   state       | meaning
//   ------------+------------------------------------------------
//   ST_RELEASED | debounced level is 1 (button up)
//   ST_PRESSED  | debounced level is 0 (button down)
// ---------------------------------------------------------------------------
module button_edge_detect #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clock,
    input  logic reset,
    input  logic button_value,
    output logic negative_edge_detected,
    output logic debounced_value
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("button_edge_detect: SYNC_STAGES must be at least 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
        $error("button_edge_detect: DEBOUNCE_CYCLES must be at least 1");
    end

    // Encoding matches the debounced level so the state bit is the output.
    typedef enum logic {
        ST_PRESSED  = 1'b0,
        ST_RELEASED = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   pulse_q, pulse_d;
    logic                   stable;

    // Synchronizer chain; flops reset to the released level so a button
    // held through reset is seen as a fresh press afterwards.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], button_value};
        end
    end

    assign s      = sync_q[SYNC_STAGES-1];
    assign stable = (state_q == ST_RELEASED);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_RELEASED;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    // Counter only advances while the synchronized sample disagrees with the
    // debounced level; any agreeing sample restarts the run. At the last
    // count the level flips, and a flip out of ST_RELEASED is a press.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        pulse_d = 1'b0;
        if (s != stable) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                case (state_q)
                    ST_RELEASED: begin
                        state_d = ST_PRESSED;
                        pulse_d = 1'b1;
                    end
                    ST_PRESSED: begin
                        state_d = ST_RELEASED;
                    end
                    default: begin
                        state_d = ST_RELEASED;
                    end
                endcase
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign negative_edge_detected = pulse_q;
    assign debounced_value        = stable;

endmodule

// File: tb/tb_button_edge_detect.sv
// ---------------------------------------------------------------------------
// tb_button_edge_detect
//
// Directed scenarios plus randomized level runs. A behavioural model tracks
// the synchronizer as a queue of past pin samples and the debouncer as a run
// length of disagreeing samples; every clock the DUT outputs are compared.
// ---------------------------------------------------------------------------
module tb_button_edge_detect;

    localparam int N = 2;
    localparam int D = 4;

    logic clock;
    logic reset;
    logic button_value;
    logic negative_edge_detected;
    logic debounced_value;

    int n_cmp;
    int n_bad;

    button_edge_detect #(
        .SYNC_STAGES    (N),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clock                 (clock),
        .reset                 (reset),
        .button_value          (button_value),
        .negative_edge_detected(negative_edge_detected),
        .debounced_value       (debounced_value)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    bit m_sync[$];   // front = newest pin sample, back = synchronized output
    bit m_stable;
    int m_run;
    bit m_pulse;
    bit m_prev_pulse;

    task automatic model_edge(input bit btn, input bit rst);
        bit s;
        if (rst) begin
            m_sync.delete();
            for (int i = 0; i < N; i++) m_sync.push_back(1'b1);
            m_stable = 1'b1;
            m_run    = 0;
            m_pulse  = 1'b0;
        end else begin
            s       = m_sync[N-1];
            m_pulse = 1'b0;
            if (s == m_stable) begin
                m_run = 0;
            end else begin
                m_run = m_run + 1;
                if (m_run == D) begin
                    m_pulse  = m_stable;   // only a 1 -> 0 change is a press
                    m_stable = s;
                    m_run    = 0;
                end
            end
            m_sync.push_front(btn);
            void'(m_sync.pop_back());
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock: drive, advance the model, compare after the edge.
    logic obs_pulse;
    logic obs_db;
    logic last_pulse;

    task automatic step(input bit btn, input bit rst);
        button_value = btn;
        reset        = rst;
        @(posedge clock);
        model_edge(btn, rst);
        #1;
        obs_pulse = negative_edge_detected;
        obs_db    = debounced_value;
        chk("pulse", {31'd0, obs_pulse}, {31'd0, m_pulse});
        chk("db", {31'd0, obs_db}, {31'd0, m_stable});
        if (obs_pulse === 1'b1 && last_pulse === 1'b1)
            chk("pulse_back_to_back", 32'd1, 32'd0);
        last_pulse = obs_pulse;
    endtask

    int first_pulse;
    int pulse_cnt;
    int db_change;

    // Hold a level for len cycles, recording pulse count, first pulse index
    // and the index where debounced_value first differs from its start.
    task automatic hold(input bit btn, input int len);
        bit db0;
        db0         = m_stable;
        first_pulse = -1;
        pulse_cnt   = 0;
        db_change   = -1;
        for (int i = 0; i < len; i++) begin
            step(btn, 1'b0);
            if (obs_pulse === 1'b1) begin
                pulse_cnt++;
                if (first_pulse < 0) first_pulse = i;
            end
            if (db_change < 0 && obs_db !== db0) db_change = i;
        end
    endtask

    initial begin
        n_cmp        = 0;
        n_bad        = 0;
        last_pulse   = 1'b0;
        button_value = 1'b1;
        reset        = 1'b1;
        model_edge(1'b1, 1'b1);

        // Reset state
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
        chk("rst_pulse", {31'd0, negative_edge_detected}, 32'd0);
        chk("rst_db", {31'd0, debounced_value}, 32'd1);
        hold(1'b1, 4);

        // Clean press, then release
        hold(1'b0, 20);
        chk("press_idx", first_pulse, 5);
        chk("press_cnt", pulse_cnt, 1);
        chk("press_db_idx", db_change, 5);
        hold(1'b1, 12);
        chk("release_cnt", pulse_cnt, 0);
        chk("release_db_idx", db_change, 5);

        // Bounce 0,1,0,0,1 then steady 0 from index 5
        begin
            bit pat[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
            int pc;
            pc = 0;
            for (int i = 0; i < 5; i++) begin
                step(pat[i], 1'b0);
                if (obs_pulse === 1'b1) pc++;
            end
            chk("bounce_quiet", pc, 0);
            hold(1'b0, 15);
            chk("bounce_idx", first_pulse, 5);
            chk("bounce_cnt", pulse_cnt, 1);
        end
        hold(1'b1, 12);

        // Short glitch
        hold(1'b0, 3);
        chk("glitch_cnt_a", pulse_cnt, 0);
        hold(1'b1, 10);
        chk("glitch_cnt_b", pulse_cnt, 0);
        chk("glitch_db", {31'd0, debounced_value}, 32'd1);
        chk("glitch_cntr", 32'(dut.cnt_q), 32'd0);

        // Press, release, press
        begin
            int total;
            hold(1'b0, 10);
            total = pulse_cnt;
            hold(1'b1, 10);
            chk("prp_release_pulse", pulse_cnt, 0);
            chk("prp_release_db_idx", db_change, 5);
            hold(1'b0, 10);
            total += pulse_cnt;
            chk("prp_total", total, 2);
        end
        hold(1'b1, 12);

        // Reset mid-count: reset at edge 3, pulse 5 edges after edge 4
        begin
            int fp;
            int pc;
            fp = -1;
            pc = 0;
            for (int i = 0; i < 20; i++) begin
                step(1'b0, i == 3);
                if (obs_pulse === 1'b1) begin
                    pc++;
                    if (fp < 0) fp = i;
                end
            end
            chk("midrst_idx", fp, 9);
            chk("midrst_cnt", pc, 1);
        end
        hold(1'b1, 12);

        // Reset during the pulse cycle
        begin
            int pc;
            hold(1'b0, 6);
            chk("pulserst_pre", first_pulse, 5);
            step(1'b0, 1'b1);
            chk("pulserst_after", {31'd0, negative_edge_detected}, 32'd0);
            pc = 0;
            for (int i = 0; i < N + D - 1; i++) begin
                step(1'b0, 1'b0);
                if (obs_pulse === 1'b1) pc++;
            end
            chk("pulserst_quiet", pc, 0);
            hold(1'b0, 10);
        end
        hold(1'b1, 12);

        // Randomized level runs with occasional reset
        for (int r = 0; r < 400; r++) begin
            bit lvl;
            int len;
            lvl = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 2 * (N + D));
            for (int i = 0; i < len; i++)
                step(lvl, $urandom_range(0, 99) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
